// File: rtl/int_to_float_pkg.sv
// Shared types and helpers for the pipelined integer-to-IEEE-754 converter.
// Rounding-mode encoding, exponent bias, derived widths and the round-increment decision.
package int_to_float_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } round_mode_t;

    localparam int RMODE_WIDTH       = 2;
    localparam int DEFAULT_INT_WIDTH = 32;
    localparam int DEFAULT_EXP_WIDTH = 8;
    localparam int DEFAULT_MAN_WIDTH = 23;
    localparam int DEFAULT_TAG_WIDTH = 4;

    function automatic int expBias(input int expWidth);
        return (1 << (expWidth - 1)) - 1;
    endfunction

    function automatic int lzWidth(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int packedWidth(input int expWidth, input int manWidth);
        return 1 + expWidth + manWidth;
    endfunction

    function automatic logic roundIncrement(
        input round_mode_t mode,
        input logic        sign,
        input logic        keptLsb,
        input logic        guardBit,
        input logic        stickyBit
    );
        logic inc;
        case (mode)
            RM_RNE:  inc = guardBit & (stickyBit | keptLsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guardBit | stickyBit);
            default: inc = !sign & (guardBit | stickyBit);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/int_to_float_pipe_if.sv
// Operand/result handshake bundle for int_to_float_pipe.
// master = producer of operands and consumer of results; slave = the converter.
interface int_to_float_pipe_if #(
    parameter int INT_WIDTH = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int TAG_WIDTH = 4
);
    import int_to_float_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [INT_WIDTH-1:0]           in_data;
    logic                           in_signed;
    round_mode_t                    in_rmode;
    logic [TAG_WIDTH-1:0]           in_tag;

    logic                           out_valid;
    logic                           out_ready;
    logic [EXP_WIDTH+MAN_WIDTH:0]   out_data;
    logic [TAG_WIDTH-1:0]           out_tag;

    modport master (
        output in_valid, in_data, in_signed, in_rmode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_rmode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/int_to_float_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module leading_zero_counter
    import int_to_float_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]          value,
    output logic [lzWidth(WIDTH)-1:0] count
);

    localparam int CW = lzWidth(WIDTH);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CW'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage integer-to-IEEE-754 converter with valid/ready handshake and tag passthrough.
// Optional INT_TO_FLOAT_FLAGS_EN adds out_inexact, sticky flag_inexact and flag_clear.
module int_to_float_pipe
    import int_to_float_pkg::*;
#(
    parameter int INT_WIDTH = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int TAG_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    int_to_float_pipe_if.slave bus
`ifdef INT_TO_FLOAT_FLAGS_EN
    ,
    output logic               out_inexact,
    output logic               flag_inexact,
    input  logic               flag_clear
`endif
);

    localparam int OUT_WIDTH  = packedWidth(EXP_WIDTH, MAN_WIDTH);
    localparam int KEPT_WIDTH = MAN_WIDTH + 1;
    localparam int LZ_WIDTH   = lzWidth(INT_WIDTH);
    localparam int BIAS       = expBias(EXP_WIDTH);

    if (INT_WIDTH < 2 || INT_WIDTH >= (1 << (EXP_WIDTH - 1))) begin : gen_width_check
        $error("int_to_float_pipe: INT_WIDTH must satisfy 2 <= INT_WIDTH < 2**(EXP_WIDTH-1)");
    end

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 1: sign/magnitude split
    logic                 inSign;
    logic [INT_WIDTH-1:0] inMag;

    always_comb begin
        inSign = bus.in_signed & bus.in_data[INT_WIDTH-1];
        inMag  = inSign ? -bus.in_data : bus.in_data;
    end

    logic                 s1Valid;
    logic                 s1Sign;
    logic                 s1Zero;
    logic [INT_WIDTH-1:0] s1Mag;
    round_mode_t          s1Rmode;
    logic [TAG_WIDTH-1:0] s1Tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1Valid <= 1'b0;
            s1Sign  <= 1'b0;
            s1Zero  <= 1'b0;
            s1Mag   <= '0;
            s1Rmode <= RM_RNE;
            s1Tag   <= '0;
        end else if (adv) begin
            s1Valid <= bus.in_valid;
            s1Sign  <= inSign;
            s1Zero  <= (bus.in_data == '0);
            s1Mag   <= inMag;
            s1Rmode <= bus.in_rmode;
            s1Tag   <= bus.in_tag;
        end
    end

    // Stage 2: normalise and extract guard/sticky
    logic [LZ_WIDTH-1:0]   lzCount;
    logic [INT_WIDTH-1:0]  norm;
    logic [EXP_WIDTH-1:0]  normExp;
    logic [KEPT_WIDTH-1:0] kept;
    logic                  guardBit;
    logic                  stickyBit;

    leading_zero_counter #(.WIDTH(INT_WIDTH)) uLzc (
        .value (s1Mag),
        .count (lzCount)
    );

    always_comb begin
        norm    = s1Mag << lzCount;
        normExp = s1Zero ? '0 : EXP_WIDTH'(BIAS + INT_WIDTH - 1) - EXP_WIDTH'(lzCount);
    end

    if (INT_WIDTH > KEPT_WIDTH) begin : gen_round
        logic [INT_WIDTH-1:0] stickyVec;
        assign stickyVec = norm << (KEPT_WIDTH + 1);
        assign kept      = norm[INT_WIDTH-1 -: KEPT_WIDTH];
        assign guardBit  = norm[INT_WIDTH-KEPT_WIDTH-1];
        assign stickyBit = |stickyVec;
    end else begin : gen_exact
        assign kept      = KEPT_WIDTH'(norm) << (KEPT_WIDTH - INT_WIDTH);
        assign guardBit  = 1'b0;
        assign stickyBit = 1'b0;
    end

    logic                  s2Valid;
    logic                  s2Sign;
    logic [EXP_WIDTH-1:0]  s2Exp;
    logic [KEPT_WIDTH-1:0] s2Kept;
    logic                  s2Guard;
    logic                  s2Sticky;
    round_mode_t           s2Rmode;
    logic [TAG_WIDTH-1:0]  s2Tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2Valid  <= 1'b0;
            s2Sign   <= 1'b0;
            s2Exp    <= '0;
            s2Kept   <= '0;
            s2Guard  <= 1'b0;
            s2Sticky <= 1'b0;
            s2Rmode  <= RM_RNE;
            s2Tag    <= '0;
        end else if (adv) begin
            s2Valid  <= s1Valid;
            s2Sign   <= s1Sign;
            s2Exp    <= normExp;
            s2Kept   <= kept;
            s2Guard  <= guardBit;
            s2Sticky <= stickyBit;
            s2Rmode  <= s1Rmode;
            s2Tag    <= s1Tag;
        end
    end

    // Stage 3: round, renormalise on carry-out, pack
    logic                  roundUp;
    logic [KEPT_WIDTH:0]   rounded;
    logic [EXP_WIDTH-1:0]  finalExp;
    logic [OUT_WIDTH-1:0]  packedResult;

    always_comb begin
        roundUp  = roundIncrement(s2Rmode, s2Sign, s2Kept[0], s2Guard, s2Sticky);
        rounded  = {1'b0, s2Kept} + (KEPT_WIDTH + 1)'(roundUp);
        finalExp = s2Exp + EXP_WIDTH'(rounded[KEPT_WIDTH]);
        // No leading one means a zero operand, which always packs as +0.
        packedResult = (rounded[KEPT_WIDTH] | rounded[MAN_WIDTH])
                     ? {s2Sign, finalExp, rounded[MAN_WIDTH-1:0]}
                     : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
        end else if (adv) begin
            bus.out_valid <= s2Valid;
            bus.out_data  <= packedResult;
            bus.out_tag   <= s2Tag;
        end
    end

`ifdef INT_TO_FLOAT_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_inexact <= 1'b0;
        end else if (adv) begin
            out_inexact <= s2Guard | s2Sticky;
        end
    end

    // A set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_inexact <= 1'b0;
        end else if (bus.out_valid && bus.out_ready && out_inexact) begin
            flag_inexact <= 1'b1;
        end else if (flag_clear) begin
            flag_inexact <= 1'b0;
        end
    end
`endif

endmodule
